cacheline_mem_arbiter: RTL and testbench
========================================

# cacheline_mem_arbiter

Shares the single cacheline-wide physical memory port between the instruction cache and the data cache of the pipelined RV32I core. It accepts miss/writeback requests from both caches and grants one at a time, round-robin when both contend. It latches the winner's command, runs it to completion on the memory side, and returns a registered one-cycle response to the winner. It sits between the two cache controllers and the memory model/bus adapter.

## Interface
- `LINE_W`, 256: cacheline width in bits.
- `ADDR_W`, 32: byte address width; addresses are line-aligned.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_read`  in  1  icache line-read request; held until `i_resp`.
- `i_address`  in  ADDR_W  icache line address.
- `i_rdata`  out  LINE_W  line returned to the icache; valid when `i_resp`.
- `i_resp`  out  1  one-cycle completion pulse to the icache.
- `d_read`  in  1  dcache line-read request.
- `d_write`  in  1  dcache line-writeback request.
- `d_address`  in  ADDR_W  dcache line address.
- `d_wdata`  in  LINE_W  writeback line.
- `d_rdata`  out  LINE_W  line returned to the dcache; valid when `d_resp`.
- `d_resp`  out  1  one-cycle completion pulse to the dcache.
- `pmem_read`, `pmem_write`  out  1 each  memory strobes; at most one is high.
- `pmem_address`  out  ADDR_W  latched address of the granted command.
- `pmem_wdata`  out  LINE_W  latched write data.
- `pmem_rdata`  in  LINE_W  memory read data; valid with `pmem_resp`.
- `pmem_resp`  in  1  memory completion; meaningful only while a strobe is high.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - SERVE_I: icache command in progress.
  - SERVE_D: dcache command in progress.
  - DONE_I: registered response pulse to the icache.
  - DONE_D: registered response pulse to the dcache.
- **Pending requests:**
  - `i_req = i_read`.
  - `d_req = d_read | d_write`.
  - If `d_read` and `d_write` are both high, the command is a write. This case is illegal, but the behaviour is defined.
- **`last_grant`** is a 1-bit register: 0 = I, 1 = D. Reset value is 1, so I wins the first contention.
- **IDLE:**
  - If `d_req` and (`!i_req` or `last_grant==I`): latch D command (address, wdata, rd/wr), set `last_grant=D`, go to SERVE_D.
  - Else if `i_req`: latch I command, set `last_grant=I`, go to SERVE_I.
  - Else stay in IDLE.
- **SERVE_x:**
  - Drive the latched strobe, address and wdata. These are constant for the whole state, and later input changes are ignored.
  - On `pmem_resp`: capture `pmem_rdata` into `x_rdata`, go to DONE_x.
  - No timeout; the state waits indefinitely.
- **DONE_x:**
  - Strobes low; `x_resp=1` for exactly this cycle.
  - Next state is always IDLE.
  - The requester drops or changes its request at this edge.
- **Read data:**
  - `i_rdata` and `d_rdata` hold their last captured value until the next capture for that port.
  - For writes, `d_rdata` is not updated.
- **Non-winning requester** waits with no response. Its inputs are not sampled until it is granted.
- **`pmem_resp` in IDLE or DONE_x** is ignored.

## Timing
- **Reset** (`rst_n` low at a rising edge):
  - State IDLE; `last_grant=1`; all strobes, `i_resp`, `d_resp` and `busy` are 0.
  - `pmem_address`, `pmem_wdata`, `i_rdata` and `d_rdata` are 0.
  - Reset mid-SERVE drops the strobe on the next cycle. A late `pmem_resp` is then ignored.
- **Outputs** are all registered or decoded from state only. There is no combinational path from request inputs or `pmem_resp` to any output.
- **Latency, request to strobe:**
  - A request seen in IDLE at cycle 0 gives a strobe from cycle 1.
  - If `pmem_resp` arrives in cycle k ≥ 1, `x_resp` is high in cycle k+1 and IDLE is reached at k+2.
  - Minimum request-to-response is 2 cycles. Back-to-back grants are spaced ≥3 cycles apart.
- **Contention:** requests that stay asserted alternate I, D, I, D. Worst-case wait is one full opposing transaction.
- **Strobe rules:** `pmem_read` and `pmem_write` are never high together. A strobe never drops before `pmem_resp`, except on reset.

## Test plan
- **Icache read:**
  - Stimulus: `i_read`, `i_address=0x0000_0040`; memory responds after 4 strobe cycles with data `0xA5..A5`.
  - Response: `pmem_read` high in cycles 1–4, `i_resp` in cycle 5 with `i_rdata=0xA5..A5`, `d_resp` never high.
- **Dcache writeback:**
  - Stimulus: `d_write`, `d_address=0x8000_0020`, `d_wdata=0x1234..`; inputs change during SERVE.
  - Response: `pmem_write` high with the original address and data throughout; one `d_resp`; `d_rdata` unchanged.
- **Simultaneous requests after reset:**
  - Stimulus: `i_read` and `d_read` both high at cycle 0.
  - Response: I served first (`last_grant` reset = D), then D. Exactly one `i_resp` followed by one `d_resp`.
- **Sustained contention:**
  - Stimulus: the dcache re-requests immediately after each response while `i_read` stays high.
  - Response: grant order I, D, I, D over 4 transactions; no requester starves.
- **Reset mid-transaction:**
  - Stimulus: `rst_n` low for 1 cycle in SERVE_D, then a late `pmem_resp`.
  - Response: strobes 0 after reset, no `d_resp`, `busy=0`, late response ignored; next `i_read` served normally.
- **Spurious memory response:**
  - Stimulus: `pmem_resp` pulsed while in IDLE.
  - Response: no state change and no `x_resp`.

Source files
------------

// File: rtl/cacheline_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_mem_arbiter_if
// Purpose  : Bus bundle between the icache/dcache controllers, the shared
//            cacheline memory port and the arbiter that multiplexes them.
// Revision : 1.0 - initial release
// ============================================================================
interface cacheline_mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);

  // icache side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // dcache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // physical memory side
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // status
  logic              busy;

  // Arbiter view: consumes requests and memory responses, drives the rest.
  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output busy
  );

  // Environment view: caches plus memory model driving into the arbiter.
  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/cacheline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_mem_arbiter
// Purpose  : Round-robin arbiter sharing one cacheline-wide memory port
//            between the instruction and data caches. The winner's command
//            is latched, run to completion, and answered with a registered
//            one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cacheline_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state;
  state_t            state_next;

  logic              last_grant;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [LINE_W-1:0] cmd_wdata;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic              i_req;
  logic              d_req;
  logic              take_i;
  logic              take_d;
  logic              capture_i;
  logic              capture_d;

  // The icache only ever reads; the dcache asks for a read or a writeback.
  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Next-state and grant decisions; requests are only looked at in IDLE
  // and memory responses only in the SERVE states.
  always_comb begin
    state_next = state;
    take_i     = 1'b0;
    take_d     = 1'b0;
    capture_i  = 1'b0;
    capture_d  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || (last_grant == GRANT_I))) begin
          take_d     = 1'b1;
          state_next = SERVE_D;
        end else if (i_req) begin
          take_i     = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          capture_i  = 1'b1;
          state_next = DONE_I;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          // A writeback returns no line, so d_rdata keeps its old value.
          capture_d  = ~cmd_write;
          state_next = DONE_D;
        end
      end
      DONE_I:  state_next = IDLE;
      DONE_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the winner's command and remember who won for round-robin.
  // Reset leaves last_grant pointing at D so the icache wins first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= GRANT_D;
      cmd_write   <= 1'b0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
    end else if (take_d) begin
      last_grant  <= GRANT_D;
      cmd_write   <= bus.d_write;
      cmd_address <= bus.d_address;
      cmd_wdata   <= bus.d_wdata;
    end else if (take_i) begin
      last_grant  <= GRANT_I;
      cmd_write   <= 1'b0;
      cmd_address <= bus.i_address;
    end
  end

  // Capture returned lines; each port holds its last line until refilled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (capture_i) begin
        i_rdata_q <= bus.pmem_rdata;
      end
      if (capture_d) begin
        d_rdata_q <= bus.pmem_rdata;
      end
    end
  end

  // Every output is a register or a decode of the state register, so no
  // request or pmem_resp input reaches an output combinationally.
  assign bus.pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !cmd_write);
  assign bus.pmem_write   = (state == SERVE_D) && cmd_write;
  assign bus.pmem_address = cmd_address;
  assign bus.pmem_wdata   = cmd_wdata;
  assign bus.i_resp       = (state == DONE_I);
  assign bus.d_resp       = (state == DONE_D);
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cacheline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_mem_arbiter
// Purpose  : Self-checking bench for cacheline_mem_arbiter: a cycle table of
//            directed vectors plus hand-written contention and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int NV     = 20;

  logic clk;
  logic rst_n;

  cacheline_mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_f : {rst_n, i_read, d_read, d_write, pmem_resp}
  // ex_f : {pmem_read, pmem_write, i_resp, d_resp, busy}
  // Data fields are 16-bit patterns replicated across the 256-bit line.
  typedef struct {
    logic        chk;
    logic [4:0]  in_f;
    logic [31:0] ia;
    logic [31:0] da;
    logic [15:0] wd;
    logic [15:0] rd;
    logic [4:0]  ex_f;
    logic [31:0] e_addr;
    logic [15:0] e_wd;
    logic [15:0] e_ird;
    logic [15:0] e_drd;
  } vec_t;

  vec_t   v [NV];
  integer checks;
  integer errors;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] out_flags();
    return {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.busy};
  endfunction

  initial begin
    logic       ok;
    int         cnt;
    logic [1:0] order [4];

    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;

    //        chk   in_f      ia          da             wd        rd        ex_f      e_addr         e_wd      e_ird     e_drd
    // reset cycle, then icache read of 0x40 with memory answering on the 4th strobe cycle
    v[0]  = '{1'b0, 5'b00000, 32'h0,     32'h0,         16'h0,    16'h0,    5'b00000, 32'h0,         16'h0,    16'h0,    16'h0};
    v[1]  = '{1'b1, 5'b11000, 32'h40,    32'h0,         16'h0,    16'h0,    5'b00000, 32'h0,         16'h0,    16'h0,    16'h0};
    v[2]  = '{1'b1, 5'b11000, 32'h40,    32'h0,         16'h0,    16'h0,    5'b10001, 32'h40,        16'h0,    16'h0,    16'h0};
    v[3]  = '{1'b1, 5'b11000, 32'h40,    32'h0,         16'h0,    16'h0,    5'b10001, 32'h40,        16'h0,    16'h0,    16'h0};
    v[4]  = '{1'b1, 5'b11000, 32'h40,    32'h0,         16'h0,    16'h0,    5'b10001, 32'h40,        16'h0,    16'h0,    16'h0};
    v[5]  = '{1'b1, 5'b11001, 32'h40,    32'h0,         16'h0,    16'hA5A5, 5'b10001, 32'h40,        16'h0,    16'h0,    16'h0};
    // DONE_I ignores a held request and a stray pmem_resp; then a spurious resp in IDLE
    v[6]  = '{1'b1, 5'b11001, 32'h40,    32'h0,         16'h0,    16'h0,    5'b00101, 32'h40,        16'h0,    16'hA5A5, 16'h0};
    v[7]  = '{1'b1, 5'b10001, 32'h0,     32'h0,         16'h0,    16'h0,    5'b00000, 32'h40,        16'h0,    16'hA5A5, 16'h0};
    // dcache writeback; address/data change during SERVE_D must not leak out
    v[8]  = '{1'b1, 5'b10010, 32'h0,     32'h8000_0020, 16'h1234, 16'h0,    5'b00000, 32'h40,        16'h0,    16'hA5A5, 16'h0};
    v[9]  = '{1'b1, 5'b10010, 32'h0,     32'hDEAD_0000, 16'hFFFF, 16'h0,    5'b01001, 32'h8000_0020, 16'h1234, 16'hA5A5, 16'h0};
    v[10] = '{1'b1, 5'b10111, 32'h0,     32'hDEAD_0000, 16'hFFFF, 16'h5A5A, 5'b01001, 32'h8000_0020, 16'h1234, 16'hA5A5, 16'h0};
    v[11] = '{1'b1, 5'b10000, 32'h0,     32'h0,         16'h0,    16'h0,    5'b00011, 32'h8000_0020, 16'h1234, 16'hA5A5, 16'h0};
    // reset, then simultaneous requests: I first, then D
    v[12] = '{1'b1, 5'b00000, 32'h0,     32'h0,         16'h0,    16'h0,    5'b00000, 32'h8000_0020, 16'h1234, 16'hA5A5, 16'h0};
    v[13] = '{1'b1, 5'b11100, 32'h100,   32'h200,       16'h7777, 16'h0,    5'b00000, 32'h0,         16'h0,    16'h0,    16'h0};
    v[14] = '{1'b1, 5'b11101, 32'h100,   32'h200,       16'h7777, 16'h1111, 5'b10001, 32'h100,       16'h0,    16'h0,    16'h0};
    v[15] = '{1'b1, 5'b11100, 32'h100,   32'h200,       16'h7777, 16'h0,    5'b00101, 32'h100,       16'h0,    16'h1111, 16'h0};
    v[16] = '{1'b1, 5'b10100, 32'h0,     32'h200,       16'h7777, 16'h0,    5'b00000, 32'h100,       16'h0,    16'h1111, 16'h0};
    v[17] = '{1'b1, 5'b10101, 32'h0,     32'h200,       16'h7777, 16'h2222, 5'b10001, 32'h200,       16'h7777, 16'h1111, 16'h0};
    v[18] = '{1'b1, 5'b10100, 32'h0,     32'h200,       16'h7777, 16'h0,    5'b00011, 32'h200,       16'h7777, 16'h1111, 16'h2222};
    v[19] = '{1'b1, 5'b10000, 32'h0,     32'h0,         16'h0,    16'h0,    5'b00000, 32'h200,       16'h7777, 16'h1111, 16'h2222};

    // Each row: outputs expected during that cycle, inputs driven for that cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (v[i].chk) begin
        check($sformatf("v%0d flags", i),   {251'b0, out_flags()},       {251'b0, v[i].ex_f});
        check($sformatf("v%0d addr", i),    {224'b0, bus.pmem_address}, {224'b0, v[i].e_addr});
        check($sformatf("v%0d wdata", i),   bus.pmem_wdata,             {16{v[i].e_wd}});
        check($sformatf("v%0d i_rdata", i), bus.i_rdata,                {16{v[i].e_ird}});
        check($sformatf("v%0d d_rdata", i), bus.d_rdata,                {16{v[i].e_drd}});
      end
      rst_n          = v[i].in_f[4];
      bus.i_read     = v[i].in_f[3];
      bus.d_read     = v[i].in_f[2];
      bus.d_write    = v[i].in_f[1];
      bus.pmem_resp  = v[i].in_f[0];
      bus.i_address  = v[i].ia;
      bus.d_address  = v[i].da;
      bus.d_wdata    = {16{v[i].wd}};
      bus.pmem_rdata = {16{v[i].rd}};
    end

    // Sustained contention: both keep requesting; grants must alternate I, D, I, D.
    @(negedge clk);
    bus.i_read    = 1'b1;
    bus.i_address = 32'h300;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h400;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.pmem_resp = bus.pmem_read | bus.pmem_write;
      if (bus.i_resp && cnt < 4) begin order[cnt] = 2'd0; cnt++; end
      if (bus.d_resp && cnt < 4) begin order[cnt] = 2'd1; cnt++; end
      if (cnt == 4) break;
    end
    check("rr_count", LINE_W'(cnt), LINE_W'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < cnt) check($sformatf("rr_order%0d", k), LINE_W'(order[k]), LINE_W'(k % 2));
    end

    // Drain whatever is in flight.
    @(negedge clk);
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.pmem_resp = bus.pmem_read | bus.pmem_write;
      if (!bus.busy) break;
    end
    bus.pmem_resp = 1'b0;

    // Reset in the middle of a dcache read, followed by a late pmem_resp.
    bus.d_read    = 1'b1;
    bus.d_address = 32'h500;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.pmem_read) begin ok = 1'b1; break; end
    end
    check("rst_strobe_seen", LINE_W'(ok), LINE_W'(1));
    rst_n      = 1'b0;
    bus.d_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_flags_after", {251'b0, out_flags()}, 256'b0);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {16{16'hBEEF}};
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("rst_late_resp", {251'b0, out_flags()}, 256'b0);
    check("rst_d_rdata", bus.d_rdata, 256'b0);
    @(negedge clk);
    check("rst_quiet", {251'b0, out_flags()}, 256'b0);

    // Next icache read is served normally.
    bus.i_read     = 1'b1;
    bus.i_address  = 32'h600;
    bus.pmem_rdata = {16{16'h6666}};
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.pmem_read) check("post_addr", {224'b0, bus.pmem_address}, {224'b0, 32'h600});
      bus.pmem_resp = bus.pmem_read | bus.pmem_write;
      if (bus.i_resp) begin ok = 1'b1; break; end
    end
    bus.i_read    = 1'b0;
    bus.pmem_resp = 1'b0;
    check("post_i_resp", LINE_W'(ok), LINE_W'(1));
    check("post_i_rdata", bus.i_rdata, {16{16'h6666}});
    check("post_d_resp", LINE_W'(bus.d_resp), LINE_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
